// File: rtl/monocicle_trace_buffer.sv
// Trace capture for the monocycle core: NCH probe channels into a circular buffer.
// Masked PC-match trigger plus post-trigger window; oldest-first random readout.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   arm, clear            start/restart capture, abort to IDLE (clear wins)
//   cap_valid, cap_data   probe sample, channel k at [k*DATA_W +: DATA_W]
//   trig_en/pc/mask       trigger compare on channel 0
//   post_count            samples kept after the trigger sample
//   state, done           0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   entries, wrapped      fill level (saturating) and overwrite flag
//   trig_idx              oldest-first index of the trigger sample
//   rd_en/idx/ch          read request, logical index, channel
//   rd_data, rd_valid     registered read result, one cycle later
module monocicle_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int NCH    = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              clear,
  input  logic              cap_valid,
  input  logic [NCH*DATA_W-1:0] cap_data,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [AW-1:0]     post_count,
  output logic [1:0]        state,
  output logic              done,
  output logic [AW:0]       entries,
  output logic              wrapped,
  output logic [AW-1:0]     trig_idx,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  input  logic [CW-1:0]     rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_E   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);
  localparam logic [AW-1:0] LAST_P  = AW'(DEPTH-1);
  localparam logic [CW:0]   NCH_V   = (CW+1)'(NCH);

  logic [NCH*DATA_W-1:0] r_mem [DEPTH];

  state_t              r_state;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW:0]         r_entries;
  logic                r_wrapped;
  logic [AW-1:0]       r_trig_ptr;
  logic [AW-1:0]       r_pc_eff;
  logic [AW-1:0]       r_post_left;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  logic                w_hit;
  logic                w_run;
  logic                w_wr;
  logic [AW-1:0]       w_oldest;
  logic [AW-1:0]       w_phys;
  logic                w_rd_ok;

  assign w_hit = cap_valid & trig_en &
    (((cap_data[DATA_W-1:0] ^ trig_pc) & trig_mask) == '0);

  assign w_run = (r_state == S_ARMED) || (r_state == S_POST);

  // arm/clear take the cycle over, so their sample is dropped
  assign w_wr = w_run & cap_valid & ~arm & ~clear;

  // once wrapped, the next write slot holds the oldest sample
  assign w_oldest = r_wrapped ? r_wr_ptr : '0;
  assign w_phys   = w_oldest + rd_idx;

  assign w_rd_ok = ({1'b0, rd_idx} < r_entries) &&
                   ({1'b0, rd_ch} < NCH_V);

  assign state    = r_state;
  assign done     = (r_state == S_DONE);
  assign entries  = r_entries;
  assign wrapped  = r_wrapped;
  assign trig_idx = r_trig_ptr - w_oldest;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= cap_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_entries   <= '0;
      r_wrapped   <= 1'b0;
      r_trig_ptr  <= '0;
      r_pc_eff    <= '0;
      r_post_left <= '0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_entries   <= '0;
      r_wrapped   <= 1'b0;
      r_trig_ptr  <= '0;
      r_post_left <= '0;
    end else if (arm) begin
      r_state     <= S_ARMED;
      r_wr_ptr    <= '0;
      r_entries   <= '0;
      r_wrapped   <= 1'b0;
      r_trig_ptr  <= '0;
      // AW-bit post_count already tops out at DEPTH-1
      r_pc_eff    <= post_count;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ONE_P;
        if (r_entries != DEPTH_V)
          r_entries <= r_entries + ONE_E;
        if (r_wr_ptr == LAST_P)
          r_wrapped <= 1'b1;
      end
      case (r_state)
        S_ARMED: begin
          if (w_hit) begin
            r_trig_ptr <= r_wr_ptr;
            if (r_pc_eff == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state     <= S_POST;
              r_post_left <= r_pc_eff;
            end
          end
        end
        S_POST: begin
          if (w_wr) begin
            r_post_left <= r_post_left - ONE_P;
            if (r_post_left == ONE_P)
              r_state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en)
        r_rd_data <= w_rd_ok ?
          r_mem[w_phys][rd_ch*DATA_W +: DATA_W] : '0;
    end
  end

endmodule

// File: tb/tb_monocicle_trace_buffer.sv
// Testbench for monocicle_trace_buffer: directed scenarios and random traffic
// checked against a queue-based model of the captured history.
module tb_monocicle_trace_buffer;

  localparam int D = 16;

  logic         clk;
  logic         rst_n;
  logic         arm;
  logic         clear;
  logic         cap_valid;
  logic [127:0] cap_data;
  logic         trig_en;
  logic [31:0]  trig_pc;
  logic [31:0]  trig_mask;
  logic [3:0]   post_count;
  logic [1:0]   state;
  logic         done;
  logic [4:0]   entries;
  logic         wrapped;
  logic [3:0]   trig_idx;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [1:0]   rd_ch;
  logic [31:0]  rd_data;
  logic         rd_valid;

  int checks = 0;
  int errors = 0;

  // model: hist holds exactly the buffered samples, oldest first
  logic [127:0] hist [$];
  int           m_state;
  int           m_n;
  int           m_trig;
  int           m_left;
  int           m_pc;
  logic [31:0]  m_rd;
  logic         m_rv;

  monocicle_trace_buffer #(
    .DATA_W(32), .DEPTH(D), .NCH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arm(arm), .clear(clear),
    .cap_valid(cap_valid), .cap_data(cap_data),
    .trig_en(trig_en), .trig_pc(trig_pc),
    .trig_mask(trig_mask), .post_count(post_count),
    .state(state), .done(done),
    .entries(entries), .wrapped(wrapped),
    .trig_idx(trig_idx),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input int i, input int c);
    logic [127:0] w;
    if (i >= hist.size()) return 32'h0;
    w = hist[i];
    return w[c*32 +: 32];
  endfunction

  function automatic logic [3:0] model_tidx();
    return 4'(m_trig - (m_n - hist.size()));
  endfunction

  task automatic model_reset();
    hist.delete();
    m_state = 0; m_n = 0; m_trig = 0;
    m_left = 0; m_pc = 0;
    m_rd = 32'h0; m_rv = 1'b0;
  endtask

  task automatic model_clock(input logic a, input logic c,
                             input logic v, input logic [127:0] d);
    logic hit;
    if (c) begin
      m_state = 0; hist.delete(); m_n = 0; m_trig = 0;
    end else if (a) begin
      m_state = 1; hist.delete(); m_n = 0; m_trig = 0;
      m_pc = int'(post_count);
    end else if ((m_state == 1 || m_state == 2) && v) begin
      hit = trig_en && (((d[31:0] ^ trig_pc) & trig_mask) == 32'h0);
      hist.push_back(d);
      m_n++;
      if (hist.size() > D) void'(hist.pop_front());
      if (m_state == 1) begin
        if (hit) begin
          m_trig = m_n - 1;
          if (m_pc == 0) m_state = 3;
          else begin m_state = 2; m_left = m_pc; end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_state = 3;
      end
    end
  endtask

  task automatic step(input logic a, input logic c, input logic v,
                      input logic [31:0] c0, input logic re,
                      input logic [3:0] ri, input logic [1:0] rc);
    logic [127:0] d;
    d = {$urandom(), $urandom(), $urandom(), c0};
    arm = a; clear = c; cap_valid = v; cap_data = d;
    rd_en = re; rd_idx = ri; rd_ch = rc;
    if (re) m_rd = model_read(int'(ri), int'(rc));
    m_rv = re;
    model_clock(a, c, v, d);
    @(posedge clk); #1;
    arm = 1'b0; clear = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 2'd0) begin errors++;
      $display("FAIL rst_state got %0d want 0", state); end
    checks++;
    if (entries !== 5'd0 || wrapped !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got e=%0d w=%0b d=%0b want 0 0 0",
               entries, wrapped, done); end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0 || trig_idx !== 4'd0) begin
      errors++;
      $display("FAIL rst_rd got v=%0b d=%h t=%0d want 0 0 0",
               rd_valid, rd_data, trig_idx); end
  endtask

  task automatic test_basic_trigger();
    trig_en = 1'b1; trig_pc = 32'h10; trig_mask = 32'hFFFF_FFFF;
    post_count = 4'd3;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 32'(k*4), 0, 0, 0);
      if (k == 6) begin
        checks++;
        if (state !== 2'd2) begin errors++;
          $display("FAIL basic_post got %0d want 2", state); end
      end
    end
    checks++;
    if (state !== 2'd3 || done !== 1'b1) begin errors++;
      $display("FAIL basic_done got s=%0d d=%0b want 3 1", state, done); end
    checks++;
    if (entries !== 5'd8 || wrapped !== 1'b0) begin errors++;
      $display("FAIL basic_fill got e=%0d w=%0b want 8 0", entries, wrapped); end
    checks++;
    if (trig_idx !== 4'd4) begin errors++;
      $display("FAIL basic_tidx got %0d want 4", trig_idx); end
    step(0, 0, 0, 0, 1, 4'd0, 2'd0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin errors++;
      $display("FAIL basic_rd0 got v=%0b d=%h want 1 0", rd_valid, rd_data); end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 0, 0, 0, 1, 4'(i), 2'(c));
        checks++;
        if (rd_data !== m_rd) begin errors++;
          $display("FAIL basic_dump[%0d][%0d] got %h want %h",
                   i, c, rd_data, m_rd); end
      end
    end
  endtask

  task automatic test_wrap();
    trig_en = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 32'(k), 0, 0, 0);
    checks++;
    if (entries !== 5'd16 || wrapped !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL wrap_flags got e=%0d w=%0b s=%0d want 16 1 1",
               entries, wrapped, state); end
    step(0, 0, 0, 0, 1, 4'd0, 2'd0);
    checks++;
    if (rd_data !== 32'd4) begin errors++;
      $display("FAIL wrap_rd0 got %0d want 4", rd_data); end
    step(0, 0, 0, 0, 1, 4'd15, 2'd0);
    checks++;
    if (rd_data !== 32'd19) begin errors++;
      $display("FAIL wrap_rd15 got %0d want 19", rd_data); end
  endtask

  task automatic test_mask();
    trig_en = 1'b1; trig_pc = 32'h40; trig_mask = 32'hFFFF_FFF0;
    post_count = 4'd0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h3C, 0, 0, 0);
    checks++;
    if (state !== 2'd1) begin errors++;
      $display("FAIL mask_nohit got %0d want 1", state); end
    step(0, 0, 1, 32'h48, 0, 0, 0);
    checks++;
    if (state !== 2'd3 || entries !== 5'd2 || trig_idx !== 4'd1) begin
      errors++;
      $display("FAIL mask_hit got s=%0d e=%0d t=%0d want 3 2 1",
               state, entries, trig_idx); end
  endtask

  task automatic test_post_clip();
    trig_en = 1'b1; trig_pc = 32'h100; trig_mask = 32'hFFFF_FFFF;
    post_count = 4'd15;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 1, 32'h101 + 32'(k), 0, 0, 0);
      if (k == 13 || k == 14) begin
        checks++;
        if (state !== ((k == 13) ? 2'd2 : 2'd3)) begin errors++;
          $display("FAIL clip_state k=%0d got %0d want %0d",
                   k, state, (k == 13) ? 2 : 3); end
      end
    end
    checks++;
    if (entries !== 5'd16 || wrapped !== 1'b1 || trig_idx !== 4'd0) begin
      errors++;
      $display("FAIL clip_flags got e=%0d w=%0b t=%0d want 16 1 0",
               entries, wrapped, trig_idx); end
    step(0, 0, 0, 0, 1, 4'd0, 2'd0);
    checks++;
    if (rd_data !== 32'h100) begin errors++;
      $display("FAIL clip_rd0 got %h want 100", rd_data); end
  endtask

  task automatic test_clear_arm();
    trig_en = 1'b1; trig_pc = 32'h10; trig_mask = 32'hFFFF_FFFF;
    post_count = 4'd5;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h10, 0, 0, 0);
    step(0, 0, 1, 32'h14, 1, 4'd5, 2'd1);
    checks++;
    if (state !== 2'd2 || rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL oob_rd got s=%0d v=%0b d=%h want 2 1 0",
               state, rd_valid, rd_data); end
    step(0, 0, 0, 0, 1, 4'd1, 2'd3);
    checks++;
    if (rd_data !== m_rd) begin errors++;
      $display("FAIL inb_rd got %h want %h", rd_data, m_rd); end
    step(1, 1, 1, 32'h18, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || entries !== 5'd0) begin errors++;
      $display("FAIL clr_arm got s=%0d e=%0d want 0 0", state, entries); end
    step(0, 0, 0, 0, 1, 4'd0, 2'd0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin errors++;
      $display("FAIL clr_rd got v=%0b d=%h want 1 0", rd_valid, rd_data); end
  endtask

  task automatic test_reset_mid_post();
    trig_en = 1'b1; trig_pc = 32'h20; trig_mask = 32'hFFFF_FFFF;
    post_count = 4'd10;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h20, 0, 0, 0);
    step(0, 0, 1, 32'h24, 1, 4'd0, 2'd0);
    checks++;
    if (state !== 2'd2 || rd_valid !== 1'b1) begin errors++;
      $display("FAIL pre_rst got s=%0d v=%0b want 2 1", state, rd_valid); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (state !== 2'd0 || entries !== 5'd0 ||
        done !== 1'b0 || rd_valid !== 1'b0) begin errors++;
      $display("FAIL async_rst got s=%0d e=%0d d=%0b v=%0b want 0 0 0 0",
               state, entries, done, rd_valid); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic a, c, v, re;
    trig_pc = 32'h40; trig_mask = 32'hFFFF_FFFC;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      trig_en = ($urandom_range(0, 9) != 0);
      post_count = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 39) == 0) ||
          (m_state == 3 && $urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      re = 1'($urandom_range(0, 1));
      step(a, c, v, 32'($urandom_range(0, 31) * 4), re,
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      checks++;
      if (state !== 2'(m_state) || done !== (m_state == 3)) begin errors++;
        $display("FAIL rnd_state n=%0d got %0d want %0d", n, state, m_state); end
      checks++;
      if (entries !== 5'(hist.size()) || wrapped !== (m_n >= D)) begin
        errors++;
        $display("FAIL rnd_fill n=%0d got e=%0d w=%0b want %0d %0b",
                 n, entries, wrapped, hist.size(), m_n >= D); end
      checks++;
      if (rd_valid !== m_rv || rd_data !== m_rd) begin errors++;
        $display("FAIL rnd_rd n=%0d got v=%0b d=%h want %0b %h",
                 n, rd_valid, rd_data, m_rv, m_rd); end
      if (m_state == 3) begin
        checks++;
        if (trig_idx !== model_tidx()) begin errors++;
          $display("FAIL rnd_tidx n=%0d got %0d want %0d",
                   n, trig_idx, model_tidx()); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; clear = 1'b0;
    cap_valid = 1'b0; cap_data = '0;
    trig_en = 1'b0; trig_pc = '0; trig_mask = '0; post_count = '0;
    rd_en = 1'b0; rd_idx = '0; rd_ch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_trigger();
    test_wrap();
    test_mask();
    test_post_clip();
    test_clear_arm();
    test_reset_mid_post();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
